clause_store: RTL and testbench
===============================

Name: clause_store

Overview:
Parametrised single-port clause memory for the hardware BCP engine; successor to the fixed 32x4 clause table.
- Adds per-entry valid bits, an occupancy counter and a full flag.
- Adds a hardware clear sweep after reset or on request, with a busy indication.
- Adds a selectable read-during-write mode and a read-acknowledge strobe.
- Sits between the clause loader (writes) and the propagation unit (reads).

Parameters:
DATA_W, 4, clause word width (literal/watch field).
ADDR_W, 5, address width.
DEPTH, 32, number of entries; must be ≤ 2**ADDR_W and ≥ 2.
RD_MODE, 0, read-during-write result: 0 = read-first (old data), 1 = write-first (new data).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  access enable; accepted only when busy=0.
we  in  1  write strobe, qualified by en.
addr  in  ADDR_W  entry address.
di  in  DATA_W  write data.
di_vld  in  1  valid bit written with di (1 = occupy, 0 = free entry).
clr_req  in  1  start a full clear sweep.
busy  out  1  clear sweep in progress; accesses are ignored.
dout  out  DATA_W  registered read data.
dout_vld  out  1  registered valid bit of the read entry.
rd_ack  out  1  one-cycle pulse; dout/dout_vld are updated this cycle.
count  out  ADDR_W+1  number of entries with valid=1.
full  out  1  count == DEPTH.

Behaviour:
- Reset (async assert) values: state=CLEAR, clr_ptr=0, busy=1, count=0, full=0, dout=0, dout_vld=0, rd_ack=0.
- FSM states are IDLE and CLEAR.
- CLEAR:
  - Each cycle, write data=0 and valid=0 at clr_ptr, then increment clr_ptr.
  - When clr_ptr==DEPTH-1, go to IDLE next cycle.
  - The sweep takes exactly DEPTH cycles; busy drops on the first IDLE cycle.
- IDLE with clr_req=1: go to CLEAR next cycle. clr_ptr=0 and count=0 take effect on entry.
- IDLE with clr_req=1 and en=1 in the same cycle: the access completes and rd_ack pulses next cycle; the sweep follows.
- clr_req during CLEAR: ignored; the sweep is not restarted.
- en=1 while busy=1: no write, no rd_ack, no count change; dout holds.
- Accepted access (IDLE, en=1):
  - rd_ack=1 next cycle; dout/dout_vld are loaded from addr (1-cycle latency).
  - Every accepted access is also a read, including writes.
- Write (we=1): update data[addr] and valid[addr].
  - With RD_MODE=0, dout returns the pre-write contents.
  - With RD_MODE=1, dout returns di/di_vld.
- en=0: rd_ack=0; dout/dout_vld hold their last value.
- Valid bits are a DEPTH-bit flop vector (async-cleared by rst). Data is an inferable RAM with no reset.
- count update on a write:
  - Old valid 0 → new 1: +1.
  - Old valid 1 → new 0: −1.
  - Otherwise unchanged.
  - count never wraps; the width holds DEPTH.
- full is combinational from count.
- Writing valid=1 to an already-valid entry overwrites the data; count is unchanged, including when full=1.
- Out-of-range addr (addr ≥ DEPTH, only when DEPTH < 2**ADDR_W):
  - The write is dropped.
  - The read returns dout=0, dout_vld=0, and rd_ack still pulses.
- Reset asserted mid-sweep or mid-access aborts it immediately. A new full sweep starts when reset deasserts.

Decomposition:
- Shared package sat_hw_pkg: default DATA_W/ADDR_W/DEPTH constants, RD_MODE encodings (RD_FIRST=0, WR_FIRST=1), FSM state enum (ST_IDLE, ST_CLEAR).
- One natural sub-module, clause_store_ram: plain single-port synchronous data array.
  - Ports: clk, en, we, addr, di, dout; parameter RD_MODE.
  - No reset.
- Valid bits, counter and FSM stay in the top.

Test Plan:
- Reset then idle, defaults: busy=1 for exactly 32 cycles after rst falls, then 0. en pulses during busy give no rd_ack. count=0.
- After the sweep: write addr=3, di=4'hA, di_vld=1, then read addr=3. Expect rd_ack each next cycle, dout=4'hA, dout_vld=1, count=1. Rewrite addr=3 with valid=1: count stays 1.
- RD_MODE=0: addr 7 holds 4'h5; write 4'hC to addr 7 → dout=4'h5. RD_MODE=1 instance, same stimulus → dout=4'hC.
- Fill addr 0..31 with valid=1 → count=32, full=1. Write addr=0 with di_vld=0 → count=31, full=0.
- clr_req with en=1 (read addr 2, valid): rd_ack and dout_vld=1 next cycle, then busy for 32 cycles; afterwards a read of addr 2 gives dout=0, dout_vld=0, count=0.
- DEPTH=20, ADDR_W=5: write addr=25 → count unchanged. Read addr=25 → rd_ack=1, dout=0, dout_vld=0. Assert rst mid-sweep at clr_ptr=10 → busy stays 1, and 20 full cycles run after release.

Source files
------------

// File: rtl/sat_hw_pkg.sv
// sat_hw_pkg: shared defaults, read-during-write encodings and clause store FSM states
package sat_hw_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF = 32;
  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
endpackage

// File: rtl/clause_store_if.sv
// clause_store_if: loader/propagation access bus of the clause store
// master drives en/we/addr/di/di_vld/clr_req; slave returns busy/dout/dout_vld/rd_ack/count/full
interface clause_store_if import sat_hw_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic en;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] di;
  logic di_vld;
  logic clr_req;
  logic busy;
  logic [DATA_W-1:0] dout;
  logic dout_vld;
  logic rd_ack;
  logic [ADDR_W:0] count;
  logic full;
  modport master (output en, we, addr, di, di_vld, clr_req, input busy, dout, dout_vld, rd_ack, count, full);
  modport slave (input en, we, addr, di, di_vld, clr_req, output busy, dout, dout_vld, rd_ack, count, full);
endinterface

// File: rtl/clause_store_ram.sv
// clause_store_ram: single-port synchronous data array, no reset
// clk; en enables access; we writes di at addr; dout registered read (old or new data by RD_MODE)
module clause_store_ram import sat_hw_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic clk,
  input  logic en,
  input  logic we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= di;
      dout <= (we && RD_MODE == WR_FIRST) ? di : mem[addr];
    end
  end
endmodule

// File: rtl/clause_store.sv
// clause_store: clause memory with valid bits, occupancy count and hardware clear sweep
// clk, rst (async, active high); bus: access (en/we/addr/di/di_vld), clr_req, busy,
// registered read (dout/dout_vld/rd_ack), occupancy (count/full)
module clause_store import sat_hw_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RD_MODE = RD_FIRST
) (
  input logic clk,
  input logic rst,
  clause_store_if.slave bus
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DEPTH-1:0] vld;
  logic [ADDR_W:0] count;
  logic clearing, acc, in_rng, old_vld, wr, ack_q, oor_q, dvld_q;
  logic [DATA_W-1:0] ram_q, held_q;
  assign clearing = state == ST_CLEAR;
  assign acc = !clearing && bus.en;
  assign in_rng = {1'b0, bus.addr} < (ADDR_W+1)'(DEPTH);
  assign old_vld = in_rng && vld[bus.addr];
  assign wr = acc && bus.we && in_rng;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLEAR;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = clearing ? (clr_ptr == ADDR_W'(DEPTH-1) ? ST_IDLE : ST_CLEAR)
                        : (bus.clr_req ? ST_CLEAR : ST_IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr <= '0;
      vld <= '0;
      count <= '0;
      ack_q <= 1'b0;
      oor_q <= 1'b0;
      dvld_q <= 1'b0;
      held_q <= '0;
    end else begin
      clr_ptr <= clearing ? clr_ptr + ADDR_W'(1) : '0;
      ack_q <= acc;
      held_q <= bus.dout;
      if (clearing) vld[clr_ptr] <= 1'b0;
      if (acc) begin
        oor_q <= !in_rng;
        dvld_q <= in_rng && ((bus.we && RD_MODE == WR_FIRST) ? bus.di_vld : old_vld);
      end
      if (wr) vld[bus.addr] <= bus.di_vld;
      count <= (!clearing && bus.clr_req) ? '0 :
               (wr && bus.di_vld && !old_vld) ? count + (ADDR_W+1)'(1) :
               (wr && !bus.di_vld && old_vld) ? count - (ADDR_W+1)'(1) : count;
    end
  end
  clause_store_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_MODE(RD_MODE)) u_ram (
    .clk(clk),
    .en(acc || clearing),
    .we(clearing || wr),
    .addr(clearing ? clr_ptr : bus.addr),
    .di(clearing ? '0 : bus.di),
    .dout(ram_q)
  );
  // RAM output moves during the sweep, so dout shows it only in the rd_ack cycle and holds otherwise
  assign bus.dout = ack_q ? (oor_q ? '0 : ram_q) : held_q;
  assign bus.dout_vld = dvld_q;
  assign bus.rd_ack = ack_q;
  assign bus.busy = clearing;
  assign bus.count = count;
  assign bus.full = count == (ADDR_W+1)'(DEPTH);
endmodule

// File: tb/tb_clause_store.sv
// tb_clause_store: directed scoreboard bench for three clause_store configurations
module tb_clause_store;
  logic clk;
  logic [2:0] rst_a, en_a, we_a, dv_a, clr_a;
  logic [2:0][4:0] addr_a;
  logic [2:0][3:0] di_a;
  logic [2:0] busy_a, ack_a, dvld_a, full_a;
  logic [2:0][3:0] dout_a;
  logic [2:0][5:0] cnt_a;
  logic [4:0] sb [$];
  int nv = 0;
  int nf = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // dut0: 32 entries read-first, dut1: 32 entries write-first, dut2: 20 entries read-first
  for (genvar g = 0; g < 3; g++) begin : u
    clause_store_if #(.DATA_W(4), .ADDR_W(5)) bus ();
    clause_store #(.DATA_W(4), .ADDR_W(5), .DEPTH(g == 2 ? 20 : 32), .RD_MODE(g == 1 ? 1 : 0)) dut (
      .clk(clk), .rst(rst_a[g]), .bus(bus));
    assign bus.en = en_a[g];
    assign bus.we = we_a[g];
    assign bus.addr = addr_a[g];
    assign bus.di = di_a[g];
    assign bus.di_vld = dv_a[g];
    assign bus.clr_req = clr_a[g];
    assign busy_a[g] = bus.busy;
    assign ack_a[g] = bus.rd_ack;
    assign dvld_a[g] = bus.dout_vld;
    assign full_a[g] = bus.full;
    assign dout_a[g] = bus.dout;
    assign cnt_a[g] = bus.count;
  end
  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    nv++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask
  task automatic acc(input int d, input logic w, input logic [4:0] a, input logic [3:0] x, input logic xv,
                     input logic c, input logic ack, input logic [3:0] ed, input logic ev);
    logic [4:0] e;
    en_a[d] = 1'b1; we_a[d] = w; addr_a[d] = a; di_a[d] = x; dv_a[d] = xv; clr_a[d] = c;
    if (ack) sb.push_back({ed, ev});
    @(posedge clk); #1;
    en_a[d] = 1'b0; we_a[d] = 1'b0; clr_a[d] = 1'b0;
    chk("rd_ack", d, 32'(ack_a[d]), 32'(ack));
    if (ack_a[d]) begin
      e = sb.size() > 0 ? sb.pop_front() : 5'bx;
      chk("rd_data", d, 32'({dout_a[d], dvld_a[d]}), 32'(e));
    end else if (ack && sb.size() > 0) e = sb.pop_front();
  endtask
  task automatic wait_busy(input int d, input int want);
    int n = 0;
    while (busy_a[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_len", d, 32'(n), 32'(want));
  endtask
  task automatic occ(input int d, input int c, input logic f);
    chk("count", d, 32'(cnt_a[d]), 32'(c));
    chk("full", d, 32'(full_a[d]), 32'(f));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    rst_a = '1; en_a = '0; we_a = '0; dv_a = '0; clr_a = '0; addr_a = '0; di_a = '0;
    repeat (2) @(posedge clk);
    #1 rst_a = '0;
    chk("rst_busy", 0, 32'(busy_a[0]), 1);
    chk("rst_dout", 0, 32'({dout_a[0], dvld_a[0], ack_a[0]}), 0);
    occ(0, 0, 0);
    acc(0, 1, 9, 4'hF, 1, 0, 0, 0, 0);
    acc(0, 1, 10, 4'hF, 1, 0, 0, 0, 0);
    wait_busy(0, 30);
    occ(0, 0, 0);
    acc(0, 1, 3, 4'hA, 1, 0, 1, 4'h0, 0);
    occ(0, 1, 0);
    acc(0, 0, 3, 4'h0, 0, 0, 1, 4'hA, 1);
    acc(0, 1, 3, 4'hB, 1, 0, 1, 4'hA, 1);
    occ(0, 1, 0);
    acc(0, 0, 9, 4'h0, 0, 0, 1, 4'h0, 0);
    acc(0, 1, 7, 4'h5, 1, 0, 1, 4'h0, 0);
    acc(0, 1, 7, 4'hC, 1, 0, 1, 4'h5, 1);
    occ(0, 2, 0);
    @(posedge clk); #1;
    chk("idle_ack", 0, 32'(ack_a[0]), 0);
    chk("hold_dout", 0, 32'({dout_a[0], dvld_a[0]}), 32'({4'h5, 1'b1}));
    for (int i = 0; i < 32; i++)
      acc(0, 1, 5'(i), 4'(i), 1, 0, 1, i == 3 ? 4'hB : i == 7 ? 4'hC : 4'h0, i == 3 || i == 7);
    occ(0, 32, 1);
    acc(0, 1, 5, 4'h9, 1, 0, 1, 4'h5, 1);
    occ(0, 32, 1);
    acc(0, 1, 0, 4'h0, 0, 0, 1, 4'h0, 1);
    occ(0, 31, 0);
    acc(0, 0, 2, 4'h0, 0, 1, 1, 4'h2, 1);
    chk("clr_busy", 0, 32'(busy_a[0]), 1);
    occ(0, 0, 0);
    wait_busy(0, 32);
    acc(0, 0, 2, 4'h0, 0, 0, 1, 4'h0, 0);
    occ(0, 0, 0);
    acc(1, 1, 7, 4'h5, 1, 0, 1, 4'h5, 1);
    acc(1, 1, 7, 4'hC, 1, 0, 1, 4'hC, 1);
    acc(1, 0, 7, 4'h0, 0, 0, 1, 4'hC, 1);
    occ(1, 1, 0);
    acc(2, 1, 25, 4'hF, 1, 0, 1, 4'h0, 0);
    occ(2, 0, 0);
    acc(2, 0, 25, 4'h0, 0, 0, 1, 4'h0, 0);
    acc(2, 1, 19, 4'h6, 1, 0, 1, 4'h0, 0);
    occ(2, 1, 0);
    acc(2, 0, 19, 4'h0, 0, 0, 1, 4'h6, 1);
    acc(2, 0, 0, 4'h0, 0, 1, 1, 4'h0, 0);
    chk("clr_busy", 2, 32'(busy_a[2]), 1);
    repeat (10) @(posedge clk);
    #1 rst_a[2] = 1'b1;
    #1;
    chk("midrst_busy", 2, 32'(busy_a[2]), 1);
    chk("midrst_out", 2, 32'({dout_a[2], dvld_a[2], ack_a[2]}), 0);
    occ(2, 0, 0);
    @(posedge clk); #1;
    rst_a[2] = 1'b0;
    n = 0;
    while (busy_a[2] && n < 200) begin
      clr_a[2] = n == 5;
      @(posedge clk); #1;
      n++;
    end
    clr_a[2] = 1'b0;
    chk("resweep_len", 2, 32'(n), 20);
    acc(2, 0, 19, 4'h0, 0, 0, 1, 4'h0, 0);
    occ(2, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
